// File: rtl/clock_calendar_alarm_if.sv
// Bundle between the clock/calendar core and its controller: tick, set-mode editing,
// alarm programming and the registered time/date/alarm outputs.
interface clock_calendar_alarm_if #(
    parameter int YEAR_W     = 7,
    parameter int NUM_ALARMS = 2
);
    logic                  tick_1s;
    logic                  set_mode;
    logic [2:0]            field_sel;
    logic                  inc;
    logic                  dec;
    logic                  alm_wr;
    logic [2:0]            alm_sel;
    logic [4:0]            alm_hour;
    logic [5:0]            alm_min;
    logic                  alm_en;
    logic [NUM_ALARMS-1:0] alm_ack;

    logic [5:0]            seconds;
    logic [5:0]            minutes;
    logic [4:0]            hours;
    logic [4:0]            day;
    logic [3:0]            month;
    logic [YEAR_W-1:0]     year;
    logic [2:0]            weekday;
    logic [NUM_ALARMS-1:0] alarm_pulse;
    logic [NUM_ALARMS-1:0] alarm_flag;

    modport master (
        output tick_1s, set_mode, field_sel, inc, dec,
        output alm_wr, alm_sel, alm_hour, alm_min, alm_en, alm_ack,
        input  seconds, minutes, hours, day, month, year, weekday,
        input  alarm_pulse, alarm_flag
    );

    modport slave (
        input  tick_1s, set_mode, field_sel, inc, dec,
        input  alm_wr, alm_sel, alm_hour, alm_min, alm_en, alm_ack,
        output seconds, minutes, hours, day, month, year, weekday,
        output alarm_pulse, alarm_flag
    );
endinterface

// File: rtl/clock_calendar_alarm.sv
// Real-time clock/calendar with leap-aware month lengths, wrap-around field editing
// and NUM_ALARMS hh:mm alarm channels with one-cycle pulses and sticky flags.
module clock_calendar_alarm #(
    parameter int YEAR_W     = 7,
    parameter int YEAR_MAX   = 99,
    parameter int NUM_ALARMS = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    clock_calendar_alarm_if.slave bus
);
    localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

    typedef enum logic [2:0] {
        F_SEC, F_MIN, F_HR, F_DAY, F_MON, F_YEAR, F_WDAY
    } field_t;

    typedef struct packed {
        logic       en;
        logic [4:0] hour;
        logic [5:0] minute;
    } alarm_cfg_t;

    logic [5:0]            sec_q, min_q, n_sec, n_min;
    logic [4:0]            hr_q, day_q, n_hr, n_day;
    logic [3:0]            mon_q, n_mon;
    logic [YEAR_W-1:0]     year_q, n_year;
    logic [2:0]            wday_q, n_wday;
    logic [4:0]            dim_now, dim_new;
    logic [NUM_ALARMS-1:0] fire, pulse_q, flag_q;
    alarm_cfg_t            cfg_q [NUM_ALARMS];
    logic                  tick_run, edit;

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [YEAR_W-1:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    // Edit step inside [lo, hi] with wrap in both directions; never carries out.
    function automatic logic [6:0] step_wrap(input logic [6:0] v, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        if (up) return (v >= hi) ? lo : v + 7'd1;
        else    return (v <= lo) ? hi : v - 7'd1;
    endfunction

    assign tick_run = !bus.set_mode && bus.tick_1s;
    assign edit     = bus.set_mode && (bus.inc ^ bus.dec);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        n_sec   = sec_q;
        n_min   = min_q;
        n_hr    = hr_q;
        n_day   = day_q;
        n_mon   = mon_q;
        n_year  = year_q;
        n_wday  = wday_q;
        dim_now = days_in_month(mon_q, year_q);
        dim_new = dim_now;
        fire    = '0;

        if (tick_run) begin
            n_sec = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            if (sec_q == 6'd59) begin
                n_min = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                if (min_q == 6'd59) begin
                    n_hr = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                    if (hr_q == 5'd23) begin
                        n_wday = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
                        if (day_q >= dim_now) begin
                            n_day = 5'd1;
                            n_mon = (mon_q == 4'd12) ? 4'd1 : mon_q + 4'd1;
                            if (mon_q == 4'd12)
                                n_year = (year_q == YMAX) ? '0 : year_q + 1'b1;
                        end else begin
                            n_day = day_q + 5'd1;
                        end
                    end
                end
            end
        end else if (edit) begin
            case (field_t'(bus.field_sel))
                F_SEC:  n_sec  = 6'(step_wrap(7'(sec_q), 7'd0, 7'd59, bus.inc));
                F_MIN:  n_min  = 6'(step_wrap(7'(min_q), 7'd0, 7'd59, bus.inc));
                F_HR:   n_hr   = 5'(step_wrap(7'(hr_q), 7'd0, 7'd23, bus.inc));
                F_DAY:  n_day  = 5'(step_wrap(7'(day_q), 7'd1, 7'(dim_now), bus.inc));
                F_WDAY: n_wday = 3'(step_wrap(7'(wday_q), 7'd0, 7'd6, bus.inc));
                F_MON: begin
                    n_mon   = 4'(step_wrap(7'(mon_q), 7'd1, 7'd12, bus.inc));
                    dim_new = days_in_month(n_mon, year_q);
                    if (day_q > dim_new) n_day = dim_new;
                end
                F_YEAR: begin
                    n_year  = YEAR_W'(step_wrap(7'(year_q), 7'd0, 7'(YEAR_MAX), bus.inc));
                    dim_new = days_in_month(mon_q, n_year);
                    if (day_q > dim_new) n_day = dim_new;
                end
                default: ;
            endcase
        end

        // Alarms compare against the post-tick time, so only a run-mode minute boundary fires.
        for (int i = 0; i < NUM_ALARMS; i++)
            fire[i] = tick_run && (n_sec == 6'd0) && cfg_q[i].en &&
                      (n_hr == cfg_q[i].hour) && (n_min == cfg_q[i].minute);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            day_q   <= 5'd1;
            mon_q   <= 4'd1;
            year_q  <= '0;
            wday_q  <= 3'd6;
            pulse_q <= '0;
            flag_q  <= '0;
            // NOTE: the alarm table is reset too, because a reset must discard alarm settings.
            for (int i = 0; i < NUM_ALARMS; i++) cfg_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            sec_q   <= n_sec;
            min_q   <= n_min;
            hr_q    <= n_hr;
            day_q   <= n_day;
            mon_q   <= n_mon;
            year_q  <= n_year;
            wday_q  <= n_wday;
            pulse_q <= fire;
            flag_q  <= fire | (flag_q & ~bus.alm_ack);
            for (int i = 0; i < NUM_ALARMS; i++)
                if (bus.alm_wr && bus.alm_sel == 3'(i))
                    cfg_q[i] <= '{en: bus.alm_en, hour: bus.alm_hour, minute: bus.alm_min};
        end
    end

    assign bus.seconds     = sec_q;
    assign bus.minutes     = min_q;
    assign bus.hours       = hr_q;
    assign bus.day         = day_q;
    assign bus.month       = mon_q;
    assign bus.year        = year_q;
    assign bus.weekday     = wday_q;
    assign bus.alarm_pulse = pulse_q;
    assign bus.alarm_flag  = flag_q;
endmodule

// File: tb/tb_clock_calendar_alarm.sv
// Directed bench for clock_calendar_alarm: rollovers, leap years, set-mode edits and alarms.
module tb_clock_calendar_alarm;
    localparam int YEAR_W = 7;
    localparam int NA     = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    clock_calendar_alarm_if #(.YEAR_W(YEAR_W), .NUM_ALARMS(NA)) bus ();

    clock_calendar_alarm #(.YEAR_W(YEAR_W), .YEAR_MAX(99), .NUM_ALARMS(NA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hours"},   int'(bus.hours),   h);
        check({tag, ".minutes"}, int'(bus.minutes), m);
        check({tag, ".seconds"}, int'(bus.seconds), s);
    endtask

    task automatic check_date(input string tag, input int d, input int mo, input int y, input int wd);
        check({tag, ".day"},     int'(bus.day),     d);
        check({tag, ".month"},   int'(bus.month),   mo);
        check({tag, ".year"},    int'(bus.year),    y);
        check({tag, ".weekday"}, int'(bus.weekday), wd);
    endtask

    // Each tick/edit ends on the negedge after its sampling posedge, so results are visible.
    task automatic tick();
        @(negedge clk) bus.tick_1s = 1'b1;
        @(negedge clk) bus.tick_1s = 1'b0;
    endtask

    task automatic edit(input int f, input bit up, input int n);
        repeat (n) begin
            @(negedge clk) begin bus.field_sel = 3'(f); bus.inc = up; bus.dec = !up; end
            @(negedge clk) begin bus.inc = 1'b0; bus.dec = 1'b0; end
        end
    endtask

    task automatic write_alarm(input int ch, input int h, input int m, input bit en);
        @(negedge clk) begin
            bus.alm_wr = 1'b1; bus.alm_sel = 3'(ch);
            bus.alm_hour = 5'(h); bus.alm_min = 6'(m); bus.alm_en = en;
        end
        @(negedge clk) bus.alm_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick_1s = 0; bus.set_mode = 0; bus.field_sel = 0; bus.inc = 0; bus.dec = 0;
        bus.alm_wr = 0; bus.alm_sel = 0; bus.alm_hour = 0; bus.alm_min = 0; bus.alm_en = 0;
        bus.alm_ack = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then three ticks
        check_time("reset", 0, 0, 0);
        check_date("reset", 1, 1, 0, 6);
        check("reset.flag", int'(bus.alarm_flag), 0);
        repeat (3) tick();
        check_time("t1", 0, 0, 3);
        check_date("t1", 1, 1, 0, 6);

        // Set-mode wraps to reach 23:59:59 12/31/99, then a full calendar rollover
        bus.set_mode = 1'b1;
        edit(0, 0, 4);
        edit(1, 0, 1);
        edit(2, 0, 1);
        edit(4, 0, 1);
        edit(3, 0, 1);
        edit(5, 0, 1);
        check_time("t2.set", 23, 59, 59);
        check_date("t2.set", 31, 12, 99, 6);
        bus.set_mode = 1'b0;
        tick();
        check_time("t2.roll", 0, 0, 0);
        check_date("t2.roll", 1, 1, 0, 0);

        // Leap year 4: Feb 28 -> Feb 29
        bus.set_mode = 1'b1;
        edit(4, 1, 1);
        edit(3, 1, 27);
        edit(5, 1, 4);
        edit(0, 0, 1);
        edit(1, 0, 1);
        edit(2, 0, 1);
        check_date("t3.set", 28, 2, 4, 0);
        bus.set_mode = 1'b0;
        tick();
        check_date("t3.leap", 29, 2, 4, 1);

        // Non-leap year 1: Feb 28 -> Mar 1
        bus.set_mode = 1'b1;
        edit(3, 0, 1);
        edit(5, 0, 3);
        edit(0, 0, 1);
        edit(1, 0, 1);
        edit(2, 0, 1);
        bus.set_mode = 1'b0;
        tick();
        check_time("t3.noleap", 0, 0, 0);
        check_date("t3.noleap", 1, 3, 1, 2);

        // Day clamping on month/year edits, day wrap, inc+dec together, field 7
        bus.set_mode = 1'b1;
        edit(4, 0, 2);
        edit(3, 0, 1);
        check("t4.jan31", int'(bus.day), 31);
        edit(4, 1, 1);
        check("t4.clamp_mon.day", int'(bus.day), 28);
        check("t4.clamp_mon.month", int'(bus.month), 2);
        edit(3, 1, 1);
        check("t4.inc_at_max", int'(bus.day), 1);
        edit(3, 0, 1);
        check("t4.dec_at_min", int'(bus.day), 28);
        @(negedge clk) begin bus.field_sel = 3'd3; bus.inc = 1; bus.dec = 1; end
        @(negedge clk) begin bus.inc = 0; bus.dec = 0; end
        check("t4.inc_dec", int'(bus.day), 28);
        edit(7, 1, 1);
        check_date("t4.field7", 28, 2, 1, 2);
        edit(5, 0, 1);
        edit(3, 1, 1);
        check("t4.leap_day", int'(bus.day), 29);
        edit(5, 1, 1);
        check("t4.clamp_year", int'(bus.day), 28);
        bus.set_mode = 1'b0;
        edit(0, 1, 1);
        check("t4.run_inc_ignored", int'(bus.seconds), 0);

        // Alarms: channel 0 enabled at 07:30, channel 1 same time but disabled
        write_alarm(0, 7, 30, 1'b1);
        write_alarm(1, 7, 30, 1'b0);
        bus.set_mode = 1'b1;
        edit(2, 1, 7);
        edit(1, 1, 29);
        edit(0, 0, 1);
        check_time("t5.set", 7, 29, 59);
        check("t5.no_edit_fire", int'(bus.alarm_flag), 0);
        bus.set_mode = 1'b0;
        tick();
        check_time("t5.fire", 7, 30, 0);
        check("t5.pulse", int'(bus.alarm_pulse), 1);
        check("t5.flag", int'(bus.alarm_flag), 1);
        @(negedge clk);
        check("t5.pulse_one_cycle", int'(bus.alarm_pulse), 0);
        check("t5.flag_sticky", int'(bus.alarm_flag), 1);
        @(negedge clk) bus.alm_ack = 2'b01;
        @(negedge clk) bus.alm_ack = 2'b00;
        check("t5.ack", int'(bus.alarm_flag), 0);

        // Re-fire coincident with ack: flag stays set
        bus.set_mode = 1'b1;
        edit(1, 0, 1);
        edit(0, 0, 1);
        bus.set_mode = 1'b0;
        @(negedge clk) begin bus.tick_1s = 1'b1; bus.alm_ack = 2'b01; end
        @(negedge clk) begin bus.tick_1s = 1'b0; bus.alm_ack = 2'b00; end
        check("t5.refire_pulse", int'(bus.alarm_pulse), 1);
        check("t5.ack_vs_fire", int'(bus.alarm_flag), 1);

        // Set mode freezes time; reset mid-count returns everything to reset values
        bus.set_mode = 1'b1;
        repeat (5) tick();
        check_time("t6.frozen", 7, 30, 0);
        bus.set_mode = 1'b0;
        repeat (2) tick();
        check_time("t6.run", 7, 30, 2);
        @(negedge clk) bus.tick_1s = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_time("t6.reset", 0, 0, 0);
        check_date("t6.reset", 1, 1, 0, 6);
        check("t6.reset.flag", int'(bus.alarm_flag), 0);
        check("t6.reset.pulse", int'(bus.alarm_pulse), 0);
        @(negedge clk) begin bus.tick_1s = 1'b0; rst_n = 1'b1; end

        // Alarm table was cleared by reset: 07:29:59 + tick must not fire
        bus.set_mode = 1'b1;
        edit(2, 1, 7);
        edit(1, 1, 29);
        edit(0, 0, 1);
        bus.set_mode = 1'b0;
        tick();
        check_time("t6.post", 7, 30, 0);
        check("t6.post.pulse", int'(bus.alarm_pulse), 0);
        check("t6.post.flag", int'(bus.alarm_flag), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
